// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared state encoding and address range check for the memory responder
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // True when the byte address lands inside a RAM of 2**aw words.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/riscv_mem_ram.sv
// rtl/riscv_mem_ram.sv - word RAM, two asynchronous read ports and one clocked write port
module riscv_mem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [31:0]       o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [31:0]       o_rdata_b
);

  logic [31:0] r_mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/riscv_mem_responder.sv
// rtl/riscv_mem_responder.sv - RV32I instruction/data memory with boot loader and core reset release
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int RELEASE_CYC = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        core_rstn,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic [31:0] instr_mem_addr,
  output logic [31:0] instr_mem_rdata,
  input  logic [31:0] data_mem_addr,
  input  logic        data_mem_write,
  input  logic [31:0] data_mem_wdata,
  output logic [31:0] data_mem_rdata,
  output logic        addr_err,
  output logic [31:0] store_count
);

  state_t      r_state;
  logic [7:0]  r_rel_cnt;
  logic        r_load_ready;
  logic        r_core_rstn;
  logic        r_addr_err;
  logic [31:0] r_store_count;

  logic              w_load_fire, w_load_ok, w_store_fire, w_data_ok, w_instr_ok;
  logic              w_we, w_err, w_unused;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_wdata, w_ram_instr, w_ram_data;

  assign w_load_fire  = (r_state == ST_LOAD) && load_valid && r_load_ready;
  assign w_store_fire = (r_state == ST_RUN) && data_mem_write;
  assign w_load_ok    = in_range(load_addr, ADDR_W);
  assign w_data_ok    = in_range(data_mem_addr, ADDR_W);
  assign w_instr_ok   = in_range(instr_mem_addr, ADDR_W);

  // The single write port belongs to the loader in LOAD and to the core otherwise.
  assign w_we    = (w_load_fire && w_load_ok) || (w_store_fire && w_data_ok);
  assign w_waddr = (r_state == ST_LOAD) ? load_addr[ADDR_W+1:2] : data_mem_addr[ADDR_W+1:2];
  assign w_wdata = (r_state == ST_LOAD) ? load_data : data_mem_wdata;

  // The fetch address is meaningless while the core is held in reset, so it is only checked in RUN.
  assign w_err = (w_load_fire && !w_load_ok) || !w_data_ok
               || ((r_state == ST_RUN) && !w_instr_ok);

  assign w_unused = ^{load_addr[1:0], instr_mem_addr[1:0], data_mem_addr[1:0]};

  riscv_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (instr_mem_addr[ADDR_W+1:2]),
    .o_rdata_a (w_ram_instr),
    .i_raddr_b (data_mem_addr[ADDR_W+1:2]),
    .o_rdata_b (w_ram_data)
  );

  assign instr_mem_rdata = w_instr_ok ? w_ram_instr : 32'h0;
  assign data_mem_rdata  = w_data_ok  ? w_ram_data  : 32'h0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_LOAD;
      r_rel_cnt     <= 8'd0;
      r_load_ready  <= 1'b0;
      r_core_rstn   <= 1'b0;
      r_addr_err    <= 1'b0;
      r_store_count <= 32'd0;
    end else begin
      if (w_err) r_addr_err <= 1'b1;
      case (r_state)
        ST_LOAD: begin
          r_load_ready <= 1'b1;
          if (w_load_fire && load_last) begin
            r_load_ready <= 1'b0;
            r_rel_cnt    <= 8'd0;
            r_state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (r_rel_cnt == 8'(RELEASE_CYC - 1)) begin
            r_core_rstn <= 1'b1;
            r_state     <= ST_RUN;
          end else begin
            r_rel_cnt <= r_rel_cnt + 8'd1;
          end
        end
        ST_RUN: begin
          if (w_store_fire && w_data_ok) r_store_count <= r_store_count + 32'd1;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign load_ready  = r_load_ready;
  assign core_rstn   = r_core_rstn;
  assign addr_err    = r_addr_err;
  assign store_count = r_store_count;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// tb/tb_riscv_mem_responder.sv - directed self-checking bench for riscv_mem_responder
module tb_riscv_mem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        core_rstn;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_last;
  logic [31:0] instr_mem_addr;
  logic [31:0] instr_mem_rdata;
  logic [31:0] data_mem_addr;
  logic        data_mem_write;
  logic [31:0] data_mem_wdata;
  logic [31:0] data_mem_rdata;
  logic        addr_err;
  logic [31:0] store_count;

  int total = 0;
  int bad   = 0;

  riscv_mem_responder #(.ADDR_W(10), .RELEASE_CYC(4)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .core_rstn       (core_rstn),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_last       (load_last),
    .instr_mem_addr  (instr_mem_addr),
    .instr_mem_rdata (instr_mem_rdata),
    .data_mem_addr   (data_mem_addr),
    .data_mem_write  (data_mem_write),
    .data_mem_wdata  (data_mem_wdata),
    .data_mem_rdata  (data_mem_rdata),
    .addr_err        (addr_err),
    .store_count     (store_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
    instr_mem_addr = '0; data_mem_addr = '0; data_mem_write = 1'b0; data_mem_wdata = '0;
    tick(); tick();
    chk("rst_core_rstn", 32'(core_rstn), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_store_count", store_count, 32'd0);

    rstn = 1'b1;
    tick();
    chk("load_ready_up", 32'(load_ready), 32'd1);

    beat(32'h0, 32'h0000_0013, 1'b0);
    beat(32'h10, 32'h0000_A5A5, 1'b0);
    // Gap with junk on the bus and a core store attempt while still in LOAD.
    load_addr = 32'h10; load_data = 32'h0000_0BAD;
    data_mem_addr = 32'h10; data_mem_write = 1'b1; data_mem_wdata = 32'hFFFF_FFFF;
    tick(); tick();
    data_mem_write = 1'b0;
    chk("gap_no_write", data_mem_rdata, 32'h0000_A5A5);
    chk("load_store_count", store_count, 32'd0);

    beat(32'h4, 32'h0010_0093, 1'b0);
    beat(32'h8, 32'h0020_8113, 1'b1);
    chk("last_ready_low", 32'(load_ready), 32'd0);
    chk("release_core_low", 32'(core_rstn), 32'd0);
    tick(); tick(); tick();
    chk("release_3cyc", 32'(core_rstn), 32'd0);
    tick();
    chk("release_4cyc", 32'(core_rstn), 32'd1);

    instr_mem_addr = 32'h4;
    #1 chk("fetch_0x4", instr_mem_rdata, 32'h0010_0093);
    instr_mem_addr = 32'h8; data_mem_addr = 32'h8;
    #1 chk("dual_read_i", instr_mem_rdata, 32'h0020_8113);
    chk("dual_read_d", data_mem_rdata, 32'h0020_8113);

    load_valid = 1'b1; load_addr = 32'h0; load_data = 32'h1; load_last = 1'b1;
    tick();
    chk("run_load_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b0; load_last = 1'b0;
    instr_mem_addr = 32'h0;
    #1 chk("run_load_ignored", instr_mem_rdata, 32'h0000_0013);

    data_mem_addr = 32'h100; data_mem_write = 1'b1; data_mem_wdata = 32'h1111_1111;
    tick();
    data_mem_wdata = 32'hDEAD_BEEF;
    #1 chk("rdw_old_word", data_mem_rdata, 32'h1111_1111);
    tick();
    data_mem_write = 1'b0;
    chk("store_new_word", data_mem_rdata, 32'hDEAD_BEEF);
    chk("store_count_2", store_count, 32'd2);
    chk("no_err_yet", 32'(addr_err), 32'd0);

    data_mem_addr = 32'h0000_1000; data_mem_write = 1'b1; data_mem_wdata = 32'h1234_5678;
    #1 chk("oob_read_zero", data_mem_rdata, 32'h0);
    tick();
    data_mem_write = 1'b0; data_mem_addr = 32'h100;
    chk("oob_err", 32'(addr_err), 32'd1);
    chk("oob_count_same", store_count, 32'd2);
    chk("oob_no_alias", instr_mem_rdata, 32'h0000_0013);

    rstn = 1'b0;
    #1 chk("run_rst_core", 32'(core_rstn), 32'd0);
    chk("run_rst_err", 32'(addr_err), 32'd0);
    chk("run_rst_count", store_count, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    beat(32'h200, 32'hCAFE_F00D, 1'b1);
    tick();
    rstn = 1'b0;
    #1 chk("rel_rst_core", 32'(core_rstn), 32'd0);
    chk("rel_rst_ready", 32'(load_ready), 32'd0);
    tick();
    rstn = 1'b1;
    #1 chk("rel_rst_ready_hold", 32'(load_ready), 32'd0);
    tick();
    chk("reload_ready", 32'(load_ready), 32'd1);
    beat(32'h204, 32'h0BAD_C0DE, 1'b1);
    tick(); tick(); tick(); tick();
    chk("reload_run", 32'(core_rstn), 32'd1);
    data_mem_addr = 32'h200;
    #1 chk("reload_keep", data_mem_rdata, 32'hCAFE_F00D);
    data_mem_addr = 32'h100;
    #1 chk("reload_keep_store", data_mem_rdata, 32'hDEAD_BEEF);
    chk("reload_err_clr", 32'(addr_err), 32'd0);

    instr_mem_addr = 32'h0000_4000;
    #1 chk("fetch_oob_zero", instr_mem_rdata, 32'h0);
    tick();
    instr_mem_addr = 32'h0;
    chk("fetch_oob_err", 32'(addr_err), 32'd1);
    tick();
    chk("err_sticky", 32'(addr_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
